// File: rtl/lcd_reg_view.sv
// -----------------------------------------------------------------------------
// lcd_reg_view
//   Display stage for the cpu16 kit. Snapshots the CPU r0/r1 register taps,
//   converts both to unsigned decimal with a sequential double dabble, and
//   writes them to a 16x2 HD44780-style LCD as "R0=ddddd" / "R1=ddddd".
//   Handles the power-up delay, the 4-command init sequence, per-byte
//   setup/enable/wait timing and a periodic refresh.
//
//   Optional feature macro: LCD_ZERO_BLANK_EN
//     defined   -> leading zero digits are sent as ' ' (d0 is always a digit)
//     undefined -> all five digits are printed, zero padded
//
// Ports
//   clk          in   system clock (50 MHz nominal)
//   rstn         in   asynchronous active-low reset
//   r0, r1       in   CPU registers, sampled only when a conversion starts
//   LCD_DATA     out  LCD data bus
//   LCD_RS       out  0 = command, 1 = character
//   LCD_RW       out  tied 0 (write-only)
//   LCD_EN       out  LCD enable strobe
//   LCD_ON       out  tied 1
//   LCD_BLON     out  tied 1
//   init_done    out  high once the init sequence has completed
//   frame_pulse  out  one-cycle pulse when the last wait of a frame ends
// -----------------------------------------------------------------------------
// State table
//   state   | meaning
//   S_PWRUP | post-reset delay, LCD untouched
//   S_CONV  | binary-to-BCD conversion, r0 then r1, one bit per cycle
//   S_SETUP | RS/DATA driven, LCD_EN still low
//   S_EN    | LCD_EN high
//   S_WAIT  | LCD_EN low, command execution time
//   S_IDLE  | refresh interval between frames
//
// Byte index idx_q: 0..3 are the init commands, 4..21 the 18 frame bytes.
// The init phase is therefore the write states with idx_q < 4.
// -----------------------------------------------------------------------------
module lcd_reg_view #(
  parameter int BW          = 16,
  parameter int PWRUP_CYC   = 750000,
  parameter int SETUP_CYC   = 2,
  parameter int EN_CYC      = 25,
  parameter int CMD_CYC     = 2000,
  parameter int CLR_CYC     = 100000,
  parameter int REFRESH_CYC = 2500000
) (
  input  logic          clk,
  input  logic          rstn,
  input  logic [BW-1:0] r0,
  input  logic [BW-1:0] r1,
  output logic [7:0]    LCD_DATA,
  output logic          LCD_RS,
  output logic          LCD_RW,
  output logic          LCD_EN,
  output logic          LCD_ON,
  output logic          LCD_BLON,
  output logic          init_done,
  output logic          frame_pulse
);

  // Shared timer width: large enough for the longest interval and for the
  // 2*BW conversion steps, which reuse the same counter.
  localparam int M1   = (PWRUP_CYC > REFRESH_CYC) ? PWRUP_CYC : REFRESH_CYC;
  localparam int M2   = (M1 > CLR_CYC) ? M1 : CLR_CYC;
  localparam int M3   = (M2 > CMD_CYC) ? M2 : CMD_CYC;
  localparam int M4   = (M3 > EN_CYC) ? M3 : EN_CYC;
  localparam int M5   = (M4 > SETUP_CYC) ? M4 : SETUP_CYC;
  localparam int MAXC = (M5 > 2 * BW) ? M5 : 2 * BW;
  localparam int CW   = $clog2(MAXC + 1);

  localparam logic [CW-1:0] TC_PWRUP   = CW'(PWRUP_CYC - 1);
  localparam logic [CW-1:0] TC_SETUP   = CW'(SETUP_CYC - 1);
  localparam logic [CW-1:0] TC_EN      = CW'(EN_CYC - 1);
  localparam logic [CW-1:0] TC_CMD     = CW'(CMD_CYC - 1);
  localparam logic [CW-1:0] TC_CLR     = CW'(CLR_CYC - 1);
  localparam logic [CW-1:0] TC_REFRESH = CW'(REFRESH_CYC - 1);
  localparam logic [CW-1:0] TC_HALF    = CW'(BW - 1);
  localparam logic [CW-1:0] TC_CONV    = CW'(2 * BW - 1);

  localparam logic [4:0] IDX_CLR         = 5'd2;
  localparam logic [4:0] IDX_INIT_LAST   = 5'd3;
  localparam logic [4:0] IDX_FRAME_FIRST = 5'd4;
  localparam logic [4:0] IDX_FRAME_LAST  = 5'd21;

  typedef enum logic [2:0] {
    S_PWRUP,
    S_CONV,
    S_SETUP,
    S_EN,
    S_WAIT,
    S_IDLE
  } state_t;

  state_t          state_q, state_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic [4:0]      idx_q, idx_d;
  logic [7:0]      data_q, data_d;
  logic            rs_q, rs_d;
  logic            en_q, en_d;
  logic            init_done_q, init_done_d;
  logic            pulse_q, pulse_d;
  logic [BW-1:0]   bin_q, bin_d;
  logic [BW-1:0]   r1s_q, r1s_d;
  logic [19:0]     bcd_q, bcd_d;
  logic [19:0]     dig0_q, dig0_d;
  logic [19:0]     dig1_q, dig1_d;

  logic [18:0]     bcd_adj;
  logic [19:0]     bcd_step;
  logic            snap;

  // Double dabble correction: +3 on every BCD digit >= 5 before the shift.
  function automatic logic [19:0] dd_adjust(input logic [19:0] b);
    logic [19:0] r;
    r = b;
    for (int k = 0; k < 5; k++) begin
      if (b[k*4 +: 4] >= 4'd5) begin
        r[k*4 +: 4] = b[k*4 +: 4] + 4'd3;
      end
    end
    return r;
  endfunction

  // ASCII for BCD digit 'pos' (4 = ten-thousands, 0 = units).
  function automatic logic [7:0] digit_char(input logic [19:0] bcd, input int pos);
    logic [7:0] c;
    c = {4'h3, bcd[pos*4 +: 4]};
`ifdef LCD_ZERO_BLANK_EN
    // Leading zero: this digit and every more significant one are zero.
    if (pos != 0 && (bcd >> (4 * pos)) == 20'd0) begin
      c = 8'h20;
    end
`endif
    return c;
  endfunction

  // {RS, DATA} for byte index 0..21.
  function automatic logic [8:0] byte_of(input logic [4:0] idx,
                                         input logic [19:0] b0,
                                         input logic [19:0] b1);
    logic [8:0] r;
    r = 9'h000;
    case (idx)
      5'd0:    r = {1'b0, 8'h38};
      5'd1:    r = {1'b0, 8'h0C};
      5'd2:    r = {1'b0, 8'h01};
      5'd3:    r = {1'b0, 8'h06};
      5'd4:    r = {1'b0, 8'h80};
      5'd5:    r = {1'b1, 8'h52};
      5'd6:    r = {1'b1, 8'h30};
      5'd7:    r = {1'b1, 8'h3D};
      5'd8:    r = {1'b1, digit_char(b0, 4)};
      5'd9:    r = {1'b1, digit_char(b0, 3)};
      5'd10:   r = {1'b1, digit_char(b0, 2)};
      5'd11:   r = {1'b1, digit_char(b0, 1)};
      5'd12:   r = {1'b1, digit_char(b0, 0)};
      5'd13:   r = {1'b0, 8'hC0};
      5'd14:   r = {1'b1, 8'h52};
      5'd15:   r = {1'b1, 8'h31};
      5'd16:   r = {1'b1, 8'h3D};
      5'd17:   r = {1'b1, digit_char(b1, 4)};
      5'd18:   r = {1'b1, digit_char(b1, 3)};
      5'd19:   r = {1'b1, digit_char(b1, 2)};
      5'd20:   r = {1'b1, digit_char(b1, 1)};
      5'd21:   r = {1'b1, digit_char(b1, 0)};
      default: r = 9'h000;
    endcase
    return r;
  endfunction

  // A 16-bit value never exceeds 6 in the top digit, so the adjusted bit 19
  // is always zero and is dropped before the shift.
  assign bcd_adj  = 19'(dd_adjust(bcd_q));
  assign bcd_step = {bcd_adj, bin_q[BW-1]};

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q + CW'(1);
    idx_d       = idx_q;
    data_d      = data_q;
    rs_d        = rs_q;
    init_done_d = init_done_q;
    pulse_d     = 1'b0;
    bin_d       = bin_q;
    r1s_d       = r1s_q;
    bcd_d       = bcd_q;
    dig0_d      = dig0_q;
    dig1_d      = dig1_q;
    snap        = 1'b0;

    case (state_q)
      S_PWRUP: begin
        if (cnt_q == TC_PWRUP) begin
          state_d = S_SETUP;
          idx_d   = 5'd0;
        end
      end
      S_SETUP: begin
        if (cnt_q == TC_SETUP) state_d = S_EN;
      end
      S_EN: begin
        if (cnt_q == TC_EN) state_d = S_WAIT;
      end
      S_WAIT: begin
        if (cnt_q == ((idx_q == IDX_CLR) ? TC_CLR : TC_CMD)) begin
          if (idx_q == IDX_INIT_LAST) begin
            init_done_d = 1'b1;
            state_d     = S_CONV;
            snap        = 1'b1;
          end else if (idx_q == IDX_FRAME_LAST) begin
            pulse_d = 1'b1;
            state_d = S_IDLE;
          end else begin
            idx_d   = idx_q + 5'd1;
            state_d = S_SETUP;
          end
        end
      end
      S_IDLE: begin
        if (cnt_q == TC_REFRESH) begin
          state_d = S_CONV;
          snap    = 1'b1;
        end
      end
      S_CONV: begin
        bcd_d = bcd_step;
        bin_d = bin_q << 1;
        if (cnt_q == TC_HALF) begin
          // r0 finished: park its digits and start on the r1 snapshot.
          dig0_d = bcd_step;
          bcd_d  = '0;
          bin_d  = r1s_q;
        end
        if (cnt_q == TC_CONV) begin
          dig1_d  = bcd_step;
          state_d = S_SETUP;
          idx_d   = IDX_FRAME_FIRST;
        end
      end
      default: state_d = S_PWRUP;
    endcase

    // Both registers are captured in the cycle the conversion starts.
    if (snap) begin
      bin_d = r0;
      r1s_d = r1;
      bcd_d = '0;
      idx_d = IDX_FRAME_FIRST;
    end

    if (state_d != state_q) cnt_d = '0;

    // RS/DATA change only when a new byte's setup begins, which gives hold
    // time through the whole wait that follows LCD_EN falling.
    if (state_d == S_SETUP && state_q != S_SETUP) begin
      {rs_d, data_d} = byte_of(idx_d, dig0_d, dig1_d);
    end

    en_d = (state_d == S_EN);
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q     <= S_PWRUP;
      cnt_q       <= '0;
      idx_q       <= '0;
      data_q      <= 8'h00;
      rs_q        <= 1'b0;
      en_q        <= 1'b0;
      init_done_q <= 1'b0;
      pulse_q     <= 1'b0;
      bin_q       <= '0;
      r1s_q       <= '0;
      bcd_q       <= '0;
      dig0_q      <= '0;
      dig1_q      <= '0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      idx_q       <= idx_d;
      data_q      <= data_d;
      rs_q        <= rs_d;
      en_q        <= en_d;
      init_done_q <= init_done_d;
      pulse_q     <= pulse_d;
      bin_q       <= bin_d;
      r1s_q       <= r1s_d;
      bcd_q       <= bcd_d;
      dig0_q      <= dig0_d;
      dig1_q      <= dig1_d;
    end
  end

  assign LCD_DATA    = data_q;
  assign LCD_RS      = rs_q;
  assign LCD_EN      = en_q;
  assign LCD_RW      = 1'b0;
  assign LCD_ON      = 1'b1;
  assign LCD_BLON    = 1'b1;
  assign init_done   = init_done_q;
  assign frame_pulse = pulse_q;

endmodule

// File: tb/tb_lcd_reg_view.sv
module tb_lcd_reg_view;

  localparam int PWRUP_CYC   = 10;
  localparam int SETUP_CYC   = 1;
  localparam int EN_CYC      = 2;
  localparam int CMD_CYC     = 5;
  localparam int CLR_CYC     = 8;
  localparam int REFRESH_CYC = 20;
  localparam int CONV_CYC    = 32;

  logic        clk  = 1'b0;
  logic        rstn = 1'b0;
  logic [15:0] r0   = 16'h0000;
  logic [15:0] r1   = 16'h0000;
  logic [7:0]  LCD_DATA;
  logic        LCD_RS, LCD_RW, LCD_EN, LCD_ON, LCD_BLON, init_done, frame_pulse;

  int n_vec = 0;
  int n_bad = 0;
  int pulse_cnt = 0;

  // Captured frame
  logic [8:0] fb     [18];
  int         fb_gap [18];
  int         fb_hi  [18];
  bit         fb_st  [18];
  bit         fb_tmo;
  int         fb_pulse0;

  lcd_reg_view #(
    .BW(16), .PWRUP_CYC(PWRUP_CYC), .SETUP_CYC(SETUP_CYC), .EN_CYC(EN_CYC),
    .CMD_CYC(CMD_CYC), .CLR_CYC(CLR_CYC), .REFRESH_CYC(REFRESH_CYC)
  ) dut (
    .clk(clk), .rstn(rstn), .r0(r0), .r1(r1),
    .LCD_DATA(LCD_DATA), .LCD_RS(LCD_RS), .LCD_RW(LCD_RW), .LCD_EN(LCD_EN),
    .LCD_ON(LCD_ON), .LCD_BLON(LCD_BLON), .init_done(init_done),
    .frame_pulse(frame_pulse)
  );

  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (frame_pulse === 1'b1) pulse_cnt++;
  end

  // Expected {RS,DATA} of frame byte i for register values v0/v1.
  function automatic logic [8:0] exp_byte(input int i, input int v0, input int v1);
    int v, p, pv, dg;
    case (i)
      0:       return {1'b0, 8'h80};
      9:       return {1'b0, 8'hC0};
      1, 10:   return {1'b1, 8'h52};
      2:       return {1'b1, 8'h30};
      11:      return {1'b1, 8'h31};
      3, 12:   return {1'b1, 8'h3D};
      default: begin
        v  = (i < 9) ? v0 : v1;
        p  = (i < 9) ? 8 - i : 17 - i;
        pv = 1;
        for (int k = 0; k < p; k++) pv = pv * 10;
        dg = (v / pv) % 10;
`ifdef LCD_ZERO_BLANK_EN
        if (p > 0 && v < pv) return {1'b1, 8'h20};
`endif
        return {1'b1, 8'h30 + 8'(dg)};
      end
    endcase
  endfunction

  // Waits (from a negedge) for the next LCD_EN pulse. gap = low samples before
  // the rise, hi = high samples, stable = RS/DATA unchanged from one sample
  // before the rise through the first sample after the fall.
  task automatic get_byte(output logic [7:0] d, output logic rs, output int gap,
                          output int hi, output bit stable, output bit tmo);
    logic [7:0] pd;
    logic       prs;
    gap = 0; hi = 0; stable = 1'b1; tmo = 1'b0;
    d = 8'h00; rs = 1'b0;
    pd = LCD_DATA; prs = LCD_RS;
    while (LCD_EN !== 1'b1) begin
      pd = LCD_DATA; prs = LCD_RS;
      @(negedge clk);
      gap++;
      if (gap > 200) begin
        tmo = 1'b1;
        return;
      end
    end
    d = LCD_DATA; rs = LCD_RS;
    if (pd !== d || prs !== rs) stable = 1'b0;
    while (LCD_EN === 1'b1) begin
      @(negedge clk);
      hi++;
      if (LCD_DATA !== d || LCD_RS !== rs) stable = 1'b0;
      if (hi > 50) begin
        tmo = 1'b1;
        return;
      end
    end
  endtask

  task automatic capture_frame(input int chg_idx, input logic [15:0] chg_val);
    logic [7:0] d;
    logic       rs;
    int         g, h;
    bit         st, t;
    fb_tmo = 1'b0;
    for (int i = 0; i < 18; i++) begin
      get_byte(d, rs, g, h, st, t);
      if (i == 0) fb_pulse0 = pulse_cnt;
      fb[i] = {rs, d}; fb_gap[i] = g; fb_hi[i] = h; fb_st[i] = st;
      if (t) fb_tmo = 1'b1;
      if (i == chg_idx) r0 = chg_val;
    end
  endtask

  task automatic test_reset();
    rstn = 1'b0; r0 = 16'h0000; r1 = 16'hFFFF;
    repeat (3) @(negedge clk);
    n_vec++;
    if ({LCD_EN, LCD_RS, LCD_DATA, init_done, frame_pulse} !== 12'h000) begin
      n_bad++;
      $display("FAIL reset_outputs got en=%b rs=%b data=%h done=%b pulse=%b want all 0",
               LCD_EN, LCD_RS, LCD_DATA, init_done, frame_pulse);
    end
    n_vec++;
    if ({LCD_RW, LCD_ON, LCD_BLON} !== 3'b011) begin
      n_bad++;
      $display("FAIL tied_outputs got rw/on/blon=%b want 011", {LCD_RW, LCD_ON, LCD_BLON});
    end
    rstn = 1'b1;
  endtask

  // Called at the negedge where rstn is released.
  task automatic test_init(input string tag);
    logic [7:0] cmds [4];
    logic [7:0] d;
    logic       rs;
    int         g, h, eg;
    bit         st, t;
    cmds = '{8'h38, 8'h0C, 8'h01, 8'h06};
    for (int i = 0; i < 4; i++) begin
      get_byte(d, rs, g, h, st, t);
      eg = (i == 0) ? PWRUP_CYC + SETUP_CYC : (i == 3) ? CLR_CYC + SETUP_CYC : CMD_CYC + SETUP_CYC;
      n_vec++;
      if (t || {rs, d} !== {1'b0, cmds[i]}) begin
        n_bad++;
        $display("FAIL %s cmd%0d got rs=%b data=%h tmo=%b want rs=0 data=%h", tag, i, rs, d, t, cmds[i]);
      end
      n_vec++;
      if (g !== eg || h !== EN_CYC || !st) begin
        n_bad++;
        $display("FAIL %s cmd%0d_timing got gap=%0d hi=%0d stable=%b want gap=%0d hi=%0d stable=1",
                 tag, i, g, h, st, eg, EN_CYC);
      end
      if (i == 3) begin
        n_vec++;
        if (init_done !== 1'b0) begin
          n_bad++;
          $display("FAIL %s done_early got %b want 0", tag, init_done);
        end
      end
    end
    // Now one sample after LCD_EN fell on 0x06; the wait lasts CMD_CYC cycles.
    repeat (CMD_CYC - 1) @(negedge clk);
    n_vec++;
    if (init_done !== 1'b0) begin
      n_bad++;
      $display("FAIL %s done_before_wait_end got %b want 0", tag, init_done);
    end
    @(negedge clk);
    n_vec++;
    if (init_done !== 1'b1) begin
      n_bad++;
      $display("FAIL %s done_after_wait got %b want 1", tag, init_done);
    end
  endtask

  // First frame after init; CMD_CYC samples of the wait were already consumed.
  task automatic test_frame_zero_ffff();
    int n;
    capture_frame(17, 16'h3039);   // set up the next frame's r0 after the last byte
    n_vec++;
    if (fb_tmo || fb_pulse0 !== 0) begin
      n_bad++;
      $display("FAIL frameA_start tmo=%b pulses=%0d want tmo=0 pulses=0", fb_tmo, fb_pulse0);
    end
    for (int i = 0; i < 18; i++) begin
      n_vec++;
      if (fb[i] !== exp_byte(i, 0, 65535)) begin
        n_bad++;
        $display("FAIL frameA_byte%0d got %h want %h", i, fb[i], exp_byte(i, 0, 65535));
      end
      n_vec++;
      if (fb_hi[i] !== EN_CYC || !fb_st[i] ||
          fb_gap[i] !== ((i == 0) ? CONV_CYC + SETUP_CYC : CMD_CYC + SETUP_CYC)) begin
        n_bad++;
        $display("FAIL frameA_timing%0d got gap=%0d hi=%0d stable=%b", i, fb_gap[i], fb_hi[i], fb_st[i]);
      end
    end
    // frame_pulse must appear exactly when the last byte's wait ends.
    n = 0;
    while (frame_pulse !== 1'b1 && n < 100) begin
      @(negedge clk);
      n++;
    end
    n_vec++;
    if (n !== CMD_CYC) begin
      n_bad++;
      $display("FAIL frame_pulse_delay got %0d want %0d", n, CMD_CYC);
    end
  endtask

  task automatic test_snapshot();
    // Frame B: snapshot 12345, r0 changed to 1 mid-frame.
    capture_frame(5, 16'h0001);
    n_vec++;
    if (fb_tmo || fb_pulse0 !== 1) begin
      n_bad++;
      $display("FAIL frameB_start tmo=%b pulses=%0d want tmo=0 pulses=1", fb_tmo, fb_pulse0);
    end
    n_vec++;
    if (fb_gap[0] !== REFRESH_CYC + CONV_CYC + SETUP_CYC) begin
      n_bad++;
      $display("FAIL frameB_gap0 got %0d want %0d", fb_gap[0], REFRESH_CYC + CONV_CYC + SETUP_CYC);
    end
    for (int i = 0; i < 18; i++) begin
      n_vec++;
      if (fb[i] !== exp_byte(i, 12345, 65535)) begin
        n_bad++;
        $display("FAIL frameB_byte%0d got %h want %h", i, fb[i], exp_byte(i, 12345, 65535));
      end
    end
  endtask

  task automatic test_back_to_back();
    // Frame C: full inter-frame gap = wait + refresh + conversion + setup.
    capture_frame(-1, 16'h0000);
    n_vec++;
    if (fb_tmo || fb_pulse0 !== 2) begin
      n_bad++;
      $display("FAIL frameC_start tmo=%b pulses=%0d want tmo=0 pulses=2", fb_tmo, fb_pulse0);
    end
    for (int i = 0; i < 18; i++) begin
      n_vec++;
      if (fb[i] !== exp_byte(i, 1, 65535)) begin
        n_bad++;
        $display("FAIL frameC_byte%0d got %h want %h", i, fb[i], exp_byte(i, 1, 65535));
      end
      n_vec++;
      if (fb_hi[i] !== EN_CYC || !fb_st[i] ||
          fb_gap[i] !== ((i == 0) ? CMD_CYC + REFRESH_CYC + CONV_CYC + SETUP_CYC
                                  : CMD_CYC + SETUP_CYC)) begin
        n_bad++;
        $display("FAIL frameC_timing%0d got gap=%0d hi=%0d stable=%b", i, fb_gap[i], fb_hi[i], fb_st[i]);
      end
    end
  endtask

  task automatic test_reset_mid_frame();
    logic [7:0] d;
    logic       rs;
    int         g, h, n;
    bit         st, t;
    for (int i = 0; i < 4; i++) get_byte(d, rs, g, h, st, t);
    n = 0;
    while (LCD_EN !== 1'b1 && n < 200) begin
      @(negedge clk);
      n++;
    end
    n_vec++;
    if (LCD_EN !== 1'b1 || init_done !== 1'b1) begin
      n_bad++;
      $display("FAIL pre_reset got en=%b done=%b want en=1 done=1", LCD_EN, init_done);
    end
    r0 = 16'd42; r1 = 16'd0;
    #2 rstn = 1'b0;
    #1;
    n_vec++;
    if ({LCD_EN, init_done, LCD_RS, LCD_DATA, frame_pulse} !== 12'h000) begin
      n_bad++;
      $display("FAIL async_reset got en=%b done=%b rs=%b data=%h pulse=%b want all 0",
               LCD_EN, init_done, LCD_RS, LCD_DATA, frame_pulse);
    end
    @(negedge clk);
    rstn = 1'b1;
    test_init("reinit");
  endtask

  task automatic test_zero_blank();
    capture_frame(-1, 16'h0000);
    n_vec++;
    if (fb_tmo || fb_pulse0 !== 3) begin
      n_bad++;
      $display("FAIL frameE_start tmo=%b pulses=%0d want tmo=0 pulses=3", fb_tmo, fb_pulse0);
    end
    for (int i = 0; i < 18; i++) begin
      n_vec++;
      if (fb[i] !== exp_byte(i, 42, 0)) begin
        n_bad++;
        $display("FAIL frameE_byte%0d got %h want %h", i, fb[i], exp_byte(i, 42, 0));
      end
    end
  endtask

  initial begin
    test_reset();
    test_init("init");
    test_frame_zero_ffff();
    test_snapshot();
    test_back_to_back();
    test_reset_mid_frame();
    test_zero_blank();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
